// File: rtl/uart_tx.sv
// UART transmit engine: start bit, 8 data bits LSB first, stop bit, each DIV_RATE clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
    parameter int DIV_RATE  = 260,
    parameter int DIV_CNT_W = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_end,
    output logic       tx
);

`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_RATE - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic [3:0]           bit_cnt;
    logic [7:0]           shift;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_end  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            tx_end <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        state   <= SEND;
                        tx_busy <= 1'b1;
                        tx      <= 1'b0;
                        shift   <= tx_data;
                        div_cnt <= '0;
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^tx_data;
`endif
                    end
                end
                SEND: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            tx_end  <= 1'b1;
                            tx      <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            // bit_cnt names the bit just finished; tx takes the one after it
                            if (bit_cnt < 4'd8) begin
                                tx    <= shift[0];
                                shift <= {1'b0, shift[7:1]};
`ifdef UART_TX_PARITY_EN
                            end else if (bit_cnt == 4'd8) begin
                                tx <= parity;
`endif
                            end else begin
                                tx <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx (DIV_RATE=4) against a frame-timing model.
module tb_uart_tx;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LOG = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_busy, tx_end, tx;

    uart_tx #(.DIV_RATE(D), .DIV_CNT_W(9)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_end(tx_end), .tx(tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Model: a frame is just "accept cycle + bit vector"; outputs follow by arithmetic.
    int   cyc = 0;
    bit   model_valid = 0;
    bit   active = 0;
    int   t0 = 0;
    bit   end_exp = 0;
    logic frame [0:10];

    always @(posedge clk) begin
        cyc++;
        end_exp = 0;
        if (reset) begin
            model_valid = 1;
            active = 0;
        end else if (active) begin
            if (cyc - t0 == NB * D) begin
                active = 0;
                end_exp = 1;
            end
        end else if (tx_start) begin
            active = 1;
            t0 = cyc;
            frame[0] = 1'b0;
            for (int i = 0; i < 8; i++) frame[1 + i] = tx_data[i];
            frame[NB - 1] = 1'b1;
            if (NB == 11) frame[9] = ^tx_data;
        end
    end

    logic txlog [0:LOG-1];
    int   end_cnt = 0;

    always @(posedge clk) begin
        #1;
        txlog[cyc % LOG] = tx;
        if (tx_end === 1'b1) end_cnt++;
        if (model_valid) begin
            chk("tx", {31'b0, tx}, {31'b0, active ? frame[(cyc - t0) / D] : 1'b1});
            chk("tx_busy", {31'b0, tx_busy}, {31'b0, active});
            chk("tx_end", {31'b0, tx_end}, {31'b0, end_exp});
        end
    end

    function automatic logic [10:0] frame_bits(input int acc);
        logic [10:0] v;
        for (int k = 0; k < 11; k++) v[k] = txlog[(acc + D * k + 2) % LOG];
        return v;
    endfunction

    task automatic send(input logic [7:0] d, output int acc);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        acc = cyc;
        tx_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (tx_end === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("tx_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int acc, e1, e2, ec0;
    logic [10:0] v;

    initial begin
        // reset held 3 cycles
        idle(3);
        reset = 1'b0;
        idle(5);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, tx_busy}, 32'd0);
        chk("rst_end", {31'b0, tx_end}, 32'd0);

        // 0x55 frame with an ignored 0xFF request during bit 3
        ec0 = end_cnt;
        send(8'h55, acc);
        idle(12);
        tx_start = 1'b1; tx_data = 8'hFF;
        idle(1);
        tx_start = 1'b0; tx_data = 8'h00;
        wait_end(100, e1);
        chk("f55_len", e1 - acc, NB * D);
        v = frame_bits(acc);
        chk("f55_bits", {23'b0, v[8:0]}, 32'b010101010);
        chk("f55_stop", {31'b0, v[NB-1]}, 32'd1);
        idle(20);
        chk("f55_one_end", end_cnt - ec0, 32'd1);

        // back-to-back: request in the tx_end cycle
        send(8'h0F, acc);
        wait_end(100, e1);
        tx_start = 1'b1; tx_data = 8'hA3;
        idle(1);
        acc = cyc;
        tx_start = 1'b0;
        chk("b2b_gap", acc - e1, 32'd1);
        chk("b2b_start", {31'b0, tx}, 32'd0);
        wait_end(100, e2);
        chk("a3_len", e2 - acc, NB * D);
        v = frame_bits(acc);
        chk("a3_bits", {23'b0, v[8:0]}, 32'b101000110);
        chk("a3_stop", {31'b0, v[NB-1]}, 32'd1);
        idle(3);

        // reset during data bit 3 of 0x3C
        ec0 = end_cnt;
        send(8'h3C, acc);
        idle(16);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_busy", {31'b0, tx_busy}, 32'd0);
        idle(50);
        chk("mid_rst_no_end", end_cnt - ec0, 32'd0);
        send(8'h00, acc);
        wait_end(100, e1);
        chk("f00_len", e1 - acc, NB * D);
        v = frame_bits(acc);
        chk("f00_bits", {23'b0, v[8:0]}, 32'b000000000);
        chk("f00_stop", {31'b0, v[NB-1]}, 32'd1);
        idle(2);

        // parity frame 0x07
        send(8'h07, acc);
        wait_end(100, e1);
`ifdef UART_TX_PARITY_EN
        chk("f07_len", e1 - acc, 32'd44);
        v = frame_bits(acc);
        chk("f07_parity", {31'b0, v[9]}, 32'd1);
`else
        chk("f07_len", e1 - acc, 32'd40);
        v = frame_bits(acc);
`endif
        chk("f07_bits", {23'b0, v[8:0]}, 32'b000001110);
        chk("f07_stop", {31'b0, v[NB-1]}, 32'd1);

        // randomised frames with stray requests mid-frame
        for (int f = 0; f < 20; f++) begin
            idle($urandom_range(0, 4));
            send(8'($urandom), acc);
            for (int k = 1; k <= NB * D - 2; k++) begin
                tx_start = ($urandom_range(0, 7) == 0);
                tx_data  = 8'($urandom);
                idle(1);
            end
            tx_start = 1'b0;
            wait_end(100, e1);
            chk("rand_len", e1 - acc, NB * D);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
